dac_spi_out: RTL

Consumes the per-sample X/Y deflection values (xch/ych) produced by the vector display core. Serialises them to an external dual-channel 12-bit SPI DAC (MCP4922-style word format):
- X is written to channel A, Y to channel B.
- Both outputs are then updated together with a single LDAC pulse, so the beam never moves diagonally in a skewed way.

The block sits between top_rtl and the board pins, in the slow/DAC clock domain. It uses a valid/ready handshake so the upstream core stalls while a frame is in flight.

---
 rtl/dac_pkg.sv | 32 +++
 rtl/spi_word_shifter.sv | 84 ++++++++
 rtl/dac_spi_out.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared types, control-bit constants and word builder for the dual-channel
// 12-bit SPI DAC serialiser (MCP4922-style command word).
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_A,
        GAP_A,
        SHIFT_B,
        GAP_B,
        LATCH
    } dac_state_e;

    localparam logic CTRL_BUF    = 1'b0;
    localparam logic CTRL_GA_N   = 1'b1;
    localparam logic CTRL_SHDN_N = 1'b1;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int unsigned DAC_WORD_W  = 16;
    localparam int unsigned DAC_DATA_W  = 12;
    localparam int unsigned LDAC_CYCLES = 2;

    function automatic logic [DAC_WORD_W-1:0] build_word(
        input logic                  ch,
        input logic [DAC_DATA_W-1:0] data
    );
        return {ch, CTRL_BUF, CTRL_GA_N, CTRL_SHDN_N, data};
    endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// 16-bit MSB-first load/shift register with SCLK divider (SPI mode 0).
// start arms exactly 32 half-periods; done pulses in the final cycle.
module spi_word_shifter
    import dac_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DAC_WORD_W-1:0] word,
    input  logic                  start,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi
);

    localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned HALF_W = $clog2(2 * DAC_WORD_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DAC_WORD_W - 1);

    logic [DAC_WORD_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic                  sclk_q, sclk_d;
    logic                  active_q, active_d;
    logic                  tick;

    assign tick = active_q && (div_q == DIV_LAST);

    always_comb begin
        shreg_d  = shreg_q;
        div_d    = div_q;
        half_d   = half_q;
        sclk_d   = sclk_q;
        active_d = active_q;
        if (load) begin
            shreg_d = word;
        end
        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            half_d   = '0;
            sclk_d   = 1'b0;
        end else if (active_q) begin
            if (tick) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                half_d = half_q + 1'b1;
                // Advance data on the falling edge so it is set up for a full low half.
                if (sclk_q) begin
                    shreg_d = {shreg_q[DAC_WORD_W-2:0], 1'b0};
                end
                if (half_q == HALF_LAST) begin
                    active_d = 1'b0;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            div_q    <= '0;
            half_q   <= '0;
            sclk_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sclk_q   <= sclk_d;
            active_q <= active_d;
        end
    end

    assign done = tick && (half_q == HALF_LAST);
    assign sclk = sclk_q;
    assign mosi = active_q & shreg_q[DAC_WORD_W-1];

endmodule

// File: rtl/dac_spi_out.sv
// X/Y sample serialiser: X to DAC channel A, Y to channel B, then one shared
// LDAC pulse. Define DAC_SPI_SKIP_DUP_EN to drop repeats of the last sent pair.
module dac_spi_out
    import dac_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned DAC_BITS  = 12,
    parameter int unsigned SCLK_DIV  = 2,
    parameter int unsigned CS_GAP    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_WIDTH-1:0] xch,
    input  logic [OUT_WIDTH-1:0] ych,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs_n,
    output logic                 ldac_n,
    output logic                 busy
);

    localparam int unsigned PAD     = DAC_BITS - OUT_WIDTH;
    localparam int unsigned CNT_MAX = (CS_GAP > LDAC_CYCLES) ? CS_GAP : LDAC_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);

    dac_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  y_q, y_d;
    logic                  sh_load;
    logic [DAC_WORD_W-1:0] sh_word;
    logic                  sh_done;
    logic                  accept;
    logic                  dup_hit;

    function automatic logic [DAC_DATA_W-1:0] pad_sample(input logic [OUT_WIDTH-1:0] s);
        logic [DAC_BITS-1:0] wide;
        wide = DAC_BITS'(s) << PAD;
        return DAC_DATA_W'(wide);
    endfunction

    assign accept = (state_q == IDLE) && sample_valid && !dup_hit;

`ifdef DAC_SPI_SKIP_DUP_EN
    logic [OUT_WIDTH-1:0] x_last_q, x_last_d;
    logic                 last_vld_q, last_vld_d;

    // y_q already holds the last transmitted Y, so only X needs its own copy.
    assign dup_hit = last_vld_q && (xch == x_last_q) && (ych == y_q);

    always_comb begin
        x_last_d   = x_last_q;
        last_vld_d = last_vld_q;
        if (accept) begin
            x_last_d   = xch;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_last_q   <= '0;
            last_vld_q <= 1'b0;
        end else begin
            x_last_q   <= x_last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        sh_load = 1'b0;
        sh_word = build_word(CH_A, pad_sample(xch));
        case (state_q)
            IDLE: begin
                // X goes straight into the shifter so bit 15 is on mosi the next cycle.
                if (accept) begin
                    state_d = SHIFT_A;
                    y_d     = ych;
                    sh_load = 1'b1;
                end
            end
            SHIFT_A: begin
                if (sh_done) begin
                    state_d = GAP_A;
                    cnt_d   = '0;
                end
            end
            GAP_A: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = SHIFT_B;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                    sh_word = build_word(CH_B, pad_sample(y_q));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT_B: begin
                if (sh_done) begin
                    state_d = GAP_B;
                    cnt_d   = '0;
                end
            end
            GAP_B: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == LDAC_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    spi_word_shifter #(
        .SCLK_DIV(SCLK_DIV)
    ) u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (sh_load),
        .word (sh_word),
        .start(sh_load),
        .done (sh_done),
        .sclk (sclk),
        .mosi (mosi)
    );

    assign sample_ready = (state_q == IDLE);
    assign busy         = ~sample_ready;
    assign cs_n         = !((state_q == SHIFT_A) || (state_q == SHIFT_B));
    assign ldac_n       = (state_q != LATCH);

endmodule
